// File: rtl/ex_wb_pipe_reg_pkg.sv
// ex_wb_pkg
// Shared definitions for the EX/WB pipeline register slice.
//   - Default widths for the ALU/Rs data path, destination register index
//     and the stall-cycle counter.
//   - ex_wb_payload_t: the packed beat carried from EX to WB, at the
//     default widths. The top level declares an equivalent struct at its
//     own parameter values.
//   - payload_width(): bit width of one packed beat for given widths.
package ex_wb_pkg;

  localparam int DATA_W_DEF     = 8;
  localparam int REG_ADDR_W_DEF = 3;
  localparam int CNT_W_DEF      = 16;

  typedef struct packed {
    logic [DATA_W_DEF-1:0]     alu;
    logic [DATA_W_DEF-1:0]     rs_data;
    logic [REG_ADDR_W_DEF-1:0] rd;
    logic                      write_mux;
    logic                      reg_write;
  } ex_wb_payload_t;

  // Field order matches ex_wb_payload_t: ALU, Rsdata, Rd, write_mux, regWrite.
  function automatic int payload_width(input int data_w, input int reg_addr_w);
    return 2 * data_w + reg_addr_w + 2;
  endfunction

endpackage

// File: rtl/ex_wb_pipe_reg_if.sv
// ex_wb_pipe_reg_if
// Bundles every EX-side, WB-side and hazard-side signal of the EX/WB
// pipeline register.
//   EX side : in_valid, in_ready, ALU_out, Rsdata_in, Rd_in,
//             write_mux_in, regWrite_in
//   WB side : out_valid, out_ready, ALU_WB_out, Rsdata_out, Rd_out,
//             write_mux_out, regWrite_out
//   Hazard  : fwd_valid, fwd_rd, fwd_data
//   Status  : stall_cnt
// Modports:
//   master : the pipeline register itself
//   slave  : the surrounding EX/WB/hazard logic (or a testbench)
interface ex_wb_pipe_reg_if
  import ex_wb_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int CNT_W      = CNT_W_DEF
);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W-1:0]     ALU_out;
  logic [DATA_W-1:0]     Rsdata_in;
  logic [REG_ADDR_W-1:0] Rd_in;
  logic                  write_mux_in;
  logic                  regWrite_in;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_W-1:0]     ALU_WB_out;
  logic [DATA_W-1:0]     Rsdata_out;
  logic [REG_ADDR_W-1:0] Rd_out;
  logic                  write_mux_out;
  logic                  regWrite_out;

  logic                  fwd_valid;
  logic [REG_ADDR_W-1:0] fwd_rd;
  logic [DATA_W-1:0]     fwd_data;

  logic [CNT_W-1:0]      stall_cnt;

  modport master (
    input  in_valid, ALU_out, Rsdata_in, Rd_in, write_mux_in, regWrite_in,
    output in_ready,
    output out_valid, ALU_WB_out, Rsdata_out, Rd_out, write_mux_out, regWrite_out,
    input  out_ready,
    output fwd_valid, fwd_rd, fwd_data,
    output stall_cnt
  );

  modport slave (
    output in_valid, ALU_out, Rsdata_in, Rd_in, write_mux_in, regWrite_in,
    input  in_ready,
    input  out_valid, ALU_WB_out, Rsdata_out, Rd_out, write_mux_out, regWrite_out,
    output out_ready,
    input  fwd_valid, fwd_rd, fwd_data,
    input  stall_cnt
  );

endinterface

// File: rtl/ex_wb_pipe_reg_skid.sv
// ex_wb_skid_buffer
// Two-slot valid/ready register stage. The main slot drives the outputs;
// the skid slot catches the one beat that can arrive after the consumer
// stops, so in_ready can be a plain flop with no path from out_ready.
// Ports:
//   clock, reset (sync, active-low), flush (sync)
//   in_valid / in_ready / in_data   : upstream handshake + payload
//   out_valid / out_ready / out_data: downstream handshake + payload
module ex_wb_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             main_valid_q, main_valid_n;
  logic             skid_valid_q, skid_valid_n;
  logic             in_ready_q;
  logic [WIDTH-1:0] main_data_q, main_data_n;
  logic [WIDTH-1:0] skid_data_q, skid_data_n;
  logic             accept;
  logic             emit;

  // in_ready_q is always !skid_valid_q, so an accept never coincides with a
  // full skid slot and neither slot can be overwritten while valid.
  always_comb begin
    main_valid_n = main_valid_q;
    skid_valid_n = skid_valid_q;
    main_data_n  = main_data_q;
    skid_data_n  = skid_data_q;
    accept       = in_valid && in_ready_q;
    emit         = main_valid_q && out_ready;
    if (emit) begin
      if (skid_valid_q) begin
        main_data_n  = skid_data_q;
        skid_valid_n = 1'b0;
      end else if (accept) begin
        main_data_n = in_data;
      end else begin
        main_valid_n = 1'b0;
      end
    end else if (accept) begin
      if (!main_valid_q) begin
        main_valid_n = 1'b1;
        main_data_n  = in_data;
      end else begin
        skid_valid_n = 1'b1;
        skid_data_n  = in_data;
      end
    end
  end

  // Reset clears everything; flush only drops the valid bits (stale payload
  // is harmless once out_valid is low). in_ready is registered from the
  // next skid state.
  always_ff @(posedge clock) begin
    if (!reset) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      main_data_q  <= '0;
      skid_data_q  <= '0;
    end else if (flush) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      main_valid_q <= main_valid_n;
      skid_valid_q <= skid_valid_n;
      in_ready_q   <= !skid_valid_n;
      main_data_q  <= main_data_n;
      skid_data_q  <= skid_data_n;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;

endmodule

// File: rtl/ex_wb_pipe_reg.sv
// ex_wb_pipe_reg
// EX/WB pipeline register with valid/ready handshake, two-entry skid
// buffer, synchronous flush, forwarding port and saturating stall counter.
// Ports:
//   clock : single clock, posedge
//   reset : synchronous, active-low
//   flush : synchronous discard of both held beats
//   bus   : ex_wb_pipe_reg_if.master -- EX handshake/payload, WB
//           handshake/payload, fwd_valid/fwd_rd/fwd_data, stall_cnt
module ex_wb_pipe_reg
  import ex_wb_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input logic               clock,
  input logic               reset,
  input logic               flush,
  ex_wb_pipe_reg_if.master  bus
);

  localparam int PAYLOAD_W = payload_width(DATA_W, REG_ADDR_W);

  typedef struct packed {
    logic [DATA_W-1:0]     alu;
    logic [DATA_W-1:0]     rs_data;
    logic [REG_ADDR_W-1:0] rd;
    logic                  write_mux;
    logic                  reg_write;
  } payload_t;

  payload_t             in_payload;
  payload_t             out_payload;
  logic [PAYLOAD_W-1:0] out_bits;
  logic                 out_valid;
  logic [CNT_W-1:0]     stall_cnt_q;

  assign in_payload = '{alu:       bus.ALU_out,
                        rs_data:   bus.Rsdata_in,
                        rd:        bus.Rd_in,
                        write_mux: bus.write_mux_in,
                        reg_write: bus.regWrite_in};

  ex_wb_skid_buffer #(.WIDTH(PAYLOAD_W)) skid (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (in_payload),
    .out_valid (out_valid),
    .out_ready (bus.out_ready),
    .out_data  (out_bits)
  );

  assign out_payload = out_bits;

  assign bus.out_valid     = out_valid;
  assign bus.ALU_WB_out    = out_payload.alu;
  assign bus.Rsdata_out    = out_payload.rs_data;
  assign bus.Rd_out        = out_payload.rd;
  assign bus.write_mux_out = out_payload.write_mux;
  assign bus.regWrite_out  = out_payload.reg_write;

  // Forwarding looks only at the registered main slot, never the live input.
  assign bus.fwd_valid = out_valid && out_payload.reg_write;
  assign bus.fwd_rd    = out_payload.rd;
  assign bus.fwd_data  = out_payload.write_mux ? out_payload.rs_data : out_payload.alu;

  // Counts cycles where WB holds a beat it is not taking; sticks at all-ones.
  always_ff @(posedge clock) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else if (out_valid && !bus.out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_ex_wb_pipe_reg.sv
// tb_ex_wb_pipe_reg
// Directed testbench for ex_wb_pipe_reg (DATA_W=8, REG_ADDR_W=3, CNT_W=4).
// A queue holds the beats the design should currently be holding, in order;
// beats are pushed when the bench offers one the design should accept and
// popped when WB should consume one. After every clock edge the outputs are
// compared against the head of that queue and a saturating stall model.
module tb_ex_wb_pipe_reg;

  localparam int DW  = 8;
  localparam int AW  = 3;
  localparam int CW  = 4;

  typedef struct packed {
    logic [DW-1:0] alu;
    logic [DW-1:0] rs;
    logic [AW-1:0] rd;
    logic          wm;
    logic          rw;
  } beat_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;

  ex_wb_pipe_reg_if #(.DATA_W(DW), .REG_ADDR_W(AW), .CNT_W(CW)) bus ();

  ex_wb_pipe_reg #(.DATA_W(DW), .REG_ADDR_W(AW), .CNT_W(CW)) dut (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  beat_t       heldQ[$];
  int          stallExp  = 0;
  int          checkCount = 0;
  int          failCount  = 0;

  // One comparison: counts it, and on mismatch counts the failure and reports.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Compares every output against the scoreboard head and stall model.
  task automatic checkAll(input string tag);
    beat_t h;
    checkOutput({tag, ".in_ready"},  32'(bus.in_ready),  32'(heldQ.size() < 2));
    checkOutput({tag, ".out_valid"}, 32'(bus.out_valid), 32'(heldQ.size() > 0));
    checkOutput({tag, ".stall_cnt"}, 32'(bus.stall_cnt), 32'(stallExp));
    if (heldQ.size() > 0) begin
      h = heldQ[0];
      checkOutput({tag, ".ALU_WB_out"},   32'(bus.ALU_WB_out),    32'(h.alu));
      checkOutput({tag, ".Rsdata_out"},   32'(bus.Rsdata_out),    32'(h.rs));
      checkOutput({tag, ".Rd_out"},       32'(bus.Rd_out),        32'(h.rd));
      checkOutput({tag, ".write_mux_out"},32'(bus.write_mux_out), 32'(h.wm));
      checkOutput({tag, ".regWrite_out"}, 32'(bus.regWrite_out),  32'(h.rw));
      checkOutput({tag, ".fwd_valid"},    32'(bus.fwd_valid),     32'(h.rw));
      checkOutput({tag, ".fwd_rd"},       32'(bus.fwd_rd),        32'(h.rd));
      checkOutput({tag, ".fwd_data"},     32'(bus.fwd_data),      32'(h.wm ? h.rs : h.alu));
    end else begin
      checkOutput({tag, ".fwd_valid"},    32'(bus.fwd_valid),     32'd0);
    end
  endtask

  // Drives one cycle of inputs, advances the model across the edge, then
  // checks the outputs shortly after the edge.
  task automatic applyStimulus(input string tag, input logic rstN, input logic fl,
                               input logic iv, input beat_t b, input logic ordy);
    logic acc;
    logic emt;
    reset            = rstN;
    flush            = fl;
    bus.in_valid     = iv;
    bus.ALU_out      = b.alu;
    bus.Rsdata_in    = b.rs;
    bus.Rd_in        = b.rd;
    bus.write_mux_in = b.wm;
    bus.regWrite_in  = b.rw;
    bus.out_ready    = ordy;
    if (!rstN) begin
      heldQ.delete();
      stallExp = 0;
    end else begin
      acc = iv && (heldQ.size() < 2);
      emt = (heldQ.size() > 0) && ordy;
      if ((heldQ.size() > 0) && !ordy && (stallExp != (1 << CW) - 1)) stallExp++;
      if (fl) begin
        heldQ.delete();
      end else begin
        if (emt) void'(heldQ.pop_front());
        if (acc) heldQ.push_back(b);
      end
    end
    @(posedge clock);
    #1;
    checkAll(tag);
  endtask

  function automatic beat_t mk(input logic [7:0] alu);
    beat_t b;
    b.alu = alu;
    b.rs  = alu ^ 8'h5A;
    b.rd  = alu[2:0];
    b.wm  = alu[3];
    b.rw  = alu[4];
    return b;
  endfunction

  beat_t fwdBeat;
  beat_t idle;

  initial begin
    idle = mk(8'h00);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.ALU_out = '0; bus.Rsdata_in = '0; bus.Rd_in = '0;
    bus.write_mux_in = 1'b0; bus.regWrite_in = 1'b0;

    // Reset held low two cycles while a beat is being offered.
    applyStimulus("reset0", 1'b0, 1'b0, 1'b1, mk(8'hFF), 1'b1);
    applyStimulus("reset1", 1'b0, 1'b1, 1'b1, mk(8'hFF), 1'b0);
    checkOutput("reset.ALU_WB_out",    32'(bus.ALU_WB_out),    32'd0);
    checkOutput("reset.Rsdata_out",    32'(bus.Rsdata_out),    32'd0);
    checkOutput("reset.Rd_out",        32'(bus.Rd_out),        32'd0);
    checkOutput("reset.write_mux_out", 32'(bus.write_mux_out), 32'd0);
    checkOutput("reset.regWrite_out",  32'(bus.regWrite_out),  32'd0);
    checkOutput("reset.fwd_rd",        32'(bus.fwd_rd),        32'd0);
    checkOutput("reset.fwd_data",      32'(bus.fwd_data),      32'd0);

    // Streaming with WB always ready: one beat per cycle, no gaps.
    applyStimulus("stream11", 1'b1, 1'b0, 1'b1, mk(8'h11), 1'b1);
    applyStimulus("stream22", 1'b1, 1'b0, 1'b1, mk(8'h22), 1'b1);
    applyStimulus("stream33", 1'b1, 1'b0, 1'b1, mk(8'h33), 1'b1);
    applyStimulus("streamDrain", 1'b1, 1'b0, 1'b0, idle, 1'b1);

    // Back-pressure: A1 in main, A2 in skid, A3 held upstream, then release.
    applyStimulus("bpA1", 1'b1, 1'b0, 1'b1, mk(8'hA1), 1'b0);
    applyStimulus("bpA2", 1'b1, 1'b0, 1'b1, mk(8'hA2), 1'b0);
    applyStimulus("bpA3w0", 1'b1, 1'b0, 1'b1, mk(8'hA3), 1'b0);
    applyStimulus("bpA3w1", 1'b1, 1'b0, 1'b1, mk(8'hA3), 1'b0);
    applyStimulus("bpA3w2", 1'b1, 1'b0, 1'b1, mk(8'hA3), 1'b0);
    checkOutput("bp.stall_count_literal", 32'(bus.stall_cnt), 32'd4);
    applyStimulus("bpRel0", 1'b1, 1'b0, 1'b1, mk(8'hA3), 1'b1);
    applyStimulus("bpRel1", 1'b1, 1'b0, 1'b1, mk(8'hA3), 1'b1);
    applyStimulus("bpDrain0", 1'b1, 1'b0, 1'b0, idle, 1'b1);
    applyStimulus("bpDrain1", 1'b1, 1'b0, 1'b0, idle, 1'b1);

    // Forwarding port: write_mux selects Rs data; then regWrite cleared.
    fwdBeat = '{alu: 8'h03, rs: 8'h7E, rd: 3'd5, wm: 1'b1, rw: 1'b1};
    applyStimulus("fwdRw1", 1'b1, 1'b0, 1'b1, fwdBeat, 1'b1);
    checkOutput("fwd.data_literal", 32'(bus.fwd_data), 32'h7E);
    fwdBeat.rw = 1'b0;
    applyStimulus("fwdRw0", 1'b1, 1'b0, 1'b1, fwdBeat, 1'b1);
    checkOutput("fwd.valid_literal", 32'(bus.fwd_valid), 32'd0);
    applyStimulus("fwdDrain", 1'b1, 1'b0, 1'b0, idle, 1'b1);

    // Flush with both slots full and a beat offered; that beat must vanish.
    applyStimulus("flB1", 1'b1, 1'b0, 1'b1, mk(8'hB1), 1'b0);
    applyStimulus("flB2", 1'b1, 1'b0, 1'b1, mk(8'hB2), 1'b0);
    applyStimulus("flush", 1'b1, 1'b1, 1'b1, mk(8'hEE), 1'b0);
    applyStimulus("postFlush0", 1'b1, 1'b0, 1'b0, idle, 1'b1);
    applyStimulus("postFlushC1", 1'b1, 1'b0, 1'b1, mk(8'hC1), 1'b1);
    applyStimulus("postFlushDrain", 1'b1, 1'b0, 1'b0, idle, 1'b1);

    // Saturation: hold one beat stalled for 20 cycles.
    applyStimulus("satLoad", 1'b1, 1'b0, 1'b1, mk(8'hD4), 1'b0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus($sformatf("sat%0d", i), 1'b1, 1'b0, 1'b0, idle, 1'b0);
    end
    checkOutput("sat.stall_cnt_literal", 32'(bus.stall_cnt), 32'd15);
    applyStimulus("satRelease", 1'b1, 1'b0, 1'b0, idle, 1'b1);

    $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
    $finish;
  end

endmodule

// File: doc/ex_wb_pipe_reg.md
# ex_wb_pipe_reg

Parametrised EX/WB pipeline register for the next-generation core. It carries the ALU result, Rs data, destination register and writeback controls from execute to writeback. It adds a valid/ready handshake with a two-entry skid buffer, so writeback back-pressure never creates a combinational ready path into EX. It also adds a synchronous flush, a registered forwarding port for hazard logic, and a saturating stall counter.

## Interface
- DATA_W, 8: width of ALU result and Rs data.
- REG_ADDR_W, 3: width of destination register index.
- CNT_W, 16: width of stall-cycle counter.
- clock  in  1  single clock; all state updates on posedge clock.
- reset  in  1  reset is synchronous and active-low.
- flush  in  1  synchronous; discards all held entries.
- in_valid  in  1  EX offers a beat.
- in_ready  out  1  registered; block can accept a beat.
- ALU_out  in  DATA_W  ALU result.
- Rsdata_in  in  DATA_W  Rs operand data.
- Rd_in  in  REG_ADDR_W  destination register.
- write_mux_in  in  1  writeback select: 1 selects Rs data, 0 selects ALU result.
- regWrite_in  in  1  register-file write enable.
- out_valid  out  1  WB beat present.
- out_ready  in  1  WB consumes the beat.
- ALU_WB_out, Rsdata_out  out  DATA_W  held payload.
- Rd_out  out  REG_ADDR_W  held payload.
- write_mux_out, regWrite_out  out  1  held payload.
- fwd_valid  out  1  out_valid && regWrite_out.
- fwd_rd  out  REG_ADDR_W  equals Rd_out.
- fwd_data  out  DATA_W  write_mux_out ? Rsdata_out : ALU_WB_out.
- stall_cnt  out  CNT_W  count of cycles with out_valid && !out_ready; saturates at all-ones.

## Operation
- accept = in_valid && in_ready; emit = out_valid && out_ready.
- Two slots: main, which drives the outputs, and skid.
- Main empty, or main emitting with skid empty, and accept: the beat loads main.
- Main full, not emitting, skid empty, and accept: the beat loads skid. in_ready is 0 from the next cycle.
- Skid full and emit: skid moves to main and skid empties. in_ready is 1 from the next cycle.
- Both slots are never overwritten while valid. Payload on the outputs is stable while out_valid && !out_ready.
- in_ready = !skid_valid, registered. It does not combinationally depend on out_ready.
- Flush, with reset high: both slots are invalidated and in_ready is set to 1. A beat offered in the flush cycle is dropped. Flush overrides emit; that emit does not count as a consumed beat for upstream accounting.
- Reset low at a clock edge: every output is 0 except in_ready, which is 1. stall_cnt is 0. Reset overrides flush, accept and emit. Reset mid-transfer drops all held beats.
- fwd_* outputs are pure functions of the main slot. No in-flight bypass of the input.

## Timing
- Latency: beat accepted at edge N appears on the outputs (out_valid=1) after edge N, i.e. in cycle N+1.
- Throughput: 1 beat per cycle while out_ready stays 1. No bubbles are inserted.
- After out_ready drops, at most one further beat is accepted, into skid, before in_ready falls.
- stall_cnt increments at an edge where out_valid && !out_ready held in the preceding cycle. It holds at 2^CNT_W−1.
- flush takes effect at the next edge. out_valid=0 in the following cycle.

## Structure
- Package ex_wb_pkg: default width constants, and a packed payload typedef {ALU, Rsdata, Rd, write_mux, regWrite}, width 2*DATA_W+REG_ADDR_W+2.
- Sub-module ex_wb_skid_buffer, parametrised by payload width: owns the two slots, valid bits, in_ready and flush.
- Top level: packs and unpacks the payload, derives fwd_*, and holds the stall counter.

## Test plan
- Reset: drive reset=0 for 2 cycles with in_valid=1 -> all outputs 0, in_ready=1, stall_cnt=0.
- Streaming: out_ready=1, push ALU_out=0x11,0x22,0x33 on consecutive cycles -> the same values on ALU_WB_out one cycle later each, in order, with no gaps.
- Back-pressure: out_ready=0 and push 0xA1,0xA2,0xA3 -> 0xA1 on outputs, 0xA2 skidded, in_ready=0 and 0xA3 held upstream. Release out_ready -> 0xA1,0xA2,0xA3 are delivered in order. stall_cnt equals the stalled cycle count.
- Forwarding: beat Rd=5, regWrite=1, write_mux=1, Rsdata=0x7E, ALU=0x03 -> fwd_valid=1, fwd_rd=5, fwd_data=0x7E. Repeat with regWrite=0 -> fwd_valid=0.
- Flush: with both slots full, assert flush together with in_valid=1 -> out_valid=0 and in_ready=1 next cycle, and the offered beat never appears.
- Saturation: CNT_W=4, hold out_ready=0 for 20 cycles with out_valid=1 -> stall_cnt=15.
